mem_stage: RTL

Data-memory stage of the Y86-64 SEQ datapath, sitting between execute and write-back. It owns the byte-addressed little-endian data memory. It performs the load or store selected by icode and hands valM to write-back. Accesses are byte-serial by default through a small FSM with a start/done handshake.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 22 ++
 rtl/dmem_bytes.sv | 31 +++
 rtl/mem_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: icode constants, memory-stage FSM state and access-class helpers
// shared by the Y86-64 SEQ memory stage.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {IDLE, XFER, DONE} mem_state_t;

    // Instructions that load a doubleword into valM.
    function automatic logic is_read(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

    // Instructions that store a doubleword to memory.
    function automatic logic is_write(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
    endfunction

    // ret/popq address through valA; everything else through valE.
    function automatic logic addr_from_vala(input logic [3:0] ic);
        return (ic == IRET) || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: request/response bundle between execute and the memory stage.
interface mem_stage_if;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        busy;
    logic        done;
    logic        dmem_error;

    modport master (
        output start, icode, valA, valE, valP,
        input  valM, busy, done, dmem_error
    );

    modport slave (
        input  start, icode, valA, valE, valP,
        output valM, busy, done, dmem_error
    );
endinterface

// File: rtl/dmem_bytes.sv
// dmem_bytes: byte RAM, synchronous write, asynchronous read. LANES adjacent
// bytes starting at addr are accessed per cycle (1 byte-serial, 8 when the
// stage is built with MEM_BURST_EN). Contents are never reset.
module dmem_bytes #(
    parameter int MEM_BYTES = 1024,
    parameter int LANES     = 1,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic                  clk,
    input  logic [LANES-1:0]      we,
    input  logic [AW-1:0]         addr,
    input  logic [LANES-1:0][7:0] wdata,
    output logic [LANES-1:0][7:0] rdata
);

    logic [7:0] mem [MEM_BYTES];

    // Byte-enabled write; lane i lands at addr+i (little-endian order).
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) mem[addr + AW'(i)] <= wdata[i];
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign rdata[i] = mem[addr + AW'(i)];
        end
    endgenerate

endmodule

// File: rtl/mem_stage.sv
// mem_stage: Y86-64 SEQ data-memory stage. Latches the request on an
// accepted start, range-checks the address, then moves the doubleword
// through dmem_bytes one byte per cycle. Define MEM_BURST_EN to move all
// 8 bytes in a single XFER cycle over a 64-bit, 8-byte-enable port.
module mem_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam int AW = $clog2(MEM_BYTES);
`ifdef MEM_BURST_EN
    localparam int LANES = 8;
`else
    localparam int LANES = 1;
`endif

    mem_state_t            state;
    logic [AW-1:0]         addr_q;
    logic [63:0]           wdata_q;
    logic                  wr_q;
    logic                  rd_q;
    logic [63:0]           valm_q;
    logic                  done_q;
    logic                  err_q;
`ifndef MEM_BURST_EN
    logic [2:0]            cnt;
`endif

    logic                  rd_op, wr_op, mem_op, range_err;
    logic [63:0]           sel_addr, sel_wdata;

    logic [LANES-1:0]      mem_we;
    logic [AW-1:0]         mem_addr;
    logic [LANES-1:0][7:0] mem_wdata, mem_rdata;

    // Decode the incoming request; the range check is 65-bit so addr+8 never wraps.
    always_comb begin
        rd_op     = is_read(bus.icode);
        wr_op     = is_write(bus.icode);
        mem_op    = rd_op | wr_op;
        sel_addr  = addr_from_vala(bus.icode) ? bus.valA : bus.valE;
        sel_wdata = (bus.icode == ICALL) ? bus.valP : bus.valA;
        range_err = ({1'b0, sel_addr} + 65'd8) > 65'(MEM_BYTES);
    end

    // Drive the RAM port from latched state only; writes happen solely in XFER.
    always_comb begin
        mem_we = {LANES{(state == XFER) && wr_q}};
`ifdef MEM_BURST_EN
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
`else
        mem_addr     = addr_q + AW'(cnt);
        mem_wdata[0] = wdata_q[{cnt, 3'b000} +: 8];
`endif
    end

    dmem_bytes #(
        .MEM_BYTES (MEM_BYTES),
        .LANES     (LANES),
        .AW        (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Access FSM: IDLE accepts, XFER moves bytes, DONE pulses done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            valm_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifndef MEM_BURST_EN
            cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q  <= sel_addr[AW-1:0];
                        wdata_q <= sel_wdata;
                        wr_q    <= wr_op;
                        rd_q    <= rd_op;
                        valm_q  <= '0;
                        err_q   <= mem_op & range_err;
`ifndef MEM_BURST_EN
                        cnt     <= '0;
`endif
                        if (mem_op && !range_err) begin
                            state <= XFER;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                XFER: begin
`ifdef MEM_BURST_EN
                    if (rd_q) valm_q <= mem_rdata;
                    state  <= DONE;
                    done_q <= 1'b1;
`else
                    if (rd_q) valm_q[{cnt, 3'b000} +: 8] <= mem_rdata[0];
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.valM       = valm_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.dmem_error = err_q;

endmodule
